// File: rtl/lcd_init_seq_if.sv
// Sequencer <-> environment bundle: refresh request, row text, byte-controller handshake and status.
// The sequencer side uses master; the byte controller / host side uses slave.
interface lcd_init_seq_if;
  logic         iGo;
  logic [127:0] iLine1;
  logic [127:0] iLine2;
  logic         iDone;
  logic         oStart;
  logic [7:0]   oData;
  logic         oRS;
  logic         oReady;
  logic         oErr;

  modport master (
    input  iGo, iLine1, iLine2, iDone,
    output oStart, oData, oRS, oReady, oErr
  );

  modport slave (
    output iGo, iLine1, iLine2, iDone,
    input  oStart, oData, oRS, oReady, oErr
  );
endinterface

// File: rtl/lcd_init_seq.sv
// HD44780-style init + two-row text writer; one byte per start/done handshake, then a settle delay.
// First start PWR_DLY+1 cycles after reset; stalls on iDone, aborts to IDLE with sticky oErr after TO_CYC wait cycles.
module lcd_init_seq #(
  parameter int PWR_DLY = 750000,
  parameter int CMD_DLY = 2500,
  parameter int CLR_DLY = 82000,
  parameter int TO_CYC  = 1024
) (
  input logic           iClk,
  input logic           iRst,
  lcd_init_seq_if.master bus
);

  localparam logic [2:0] PWR_WAIT = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] START    = 3'd2;
  localparam logic [2:0] WAIT_LO  = 3'd3;
  localparam logic [2:0] WAIT_HI  = 3'd4;
  localparam logic [2:0] DELAY    = 3'd5;
  localparam logic [2:0] IDLE     = 3'd6;

  localparam logic [19:0] PWR_END = 20'(PWR_DLY - 1);
  localparam logic [19:0] CMD_END = 20'(CMD_DLY - 1);
  localparam logic [19:0] CLR_END = 20'(CLR_DLY - 1);
  localparam logic [19:0] TO_END  = 20'(TO_CYC - 1);

  localparam logic [5:0] STEP_CLR   = 6'd2;
  localparam logic [5:0] STEP_ROW0  = 6'd4;
  localparam logic [5:0] STEP_ROW1  = 6'd21;
  localparam logic [5:0] STEP_LAST  = 6'd37;

  logic [2:0]   state;
  logic [5:0]   step;
  logic [19:0]  cnt;
  logic [255:0] shadow;
  logic         start_q;
  logic [7:0]   data_q;
  logic         rs_q;
  logic         ready_q;
  logic         err_q;

  logic [4:0]   char_idx;
  logic [7:0]   char_pos;
  logic [7:0]   step_dat;
  logic         step_rs;
  logic [19:0]  dly_end;

  // Row 0 occupies shadow[255:128], row 1 shadow[127:0]; column 0 is the top byte of each row.
  always_comb begin
    char_idx = (step <= 6'd20) ? 5'(step - 6'd5) : 5'(step - 6'd6);
    char_pos = 8'd255 - {char_idx, 3'b000};
    step_rs  = (step >= 6'd5) && (step != STEP_ROW1);
    dly_end  = (step == STEP_CLR) ? CLR_END : CMD_END;
    case (step)
      6'd0:      step_dat = 8'h38;
      6'd1:      step_dat = 8'h0C;
      6'd2:      step_dat = 8'h01;
      6'd3:      step_dat = 8'h06;
      STEP_ROW0: step_dat = 8'h80;
      STEP_ROW1: step_dat = 8'hC0;
      default:   step_dat = shadow[char_pos -: 8];
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= PWR_WAIT;
      step    <= 6'd0;
      cnt     <= 20'd0;
      shadow  <= 256'd0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        PWR_WAIT: begin
          if (cnt == PWR_END) begin
            cnt   <= 20'd0;
            state <= LOAD;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end

        LOAD: begin
          data_q  <= step_dat;
          rs_q    <= step_rs;
          // Text is frozen per pass so a host edit mid-refresh cannot tear a row.
          if (step == STEP_ROW0) shadow <= {bus.iLine1, bus.iLine2};
          start_q <= 1'b1;
          state   <= START;
        end

        START: begin
          cnt   <= 20'd0;
          state <= WAIT_LO;
        end

        WAIT_LO, WAIT_HI: begin
          if (state == WAIT_LO && !bus.iDone) begin
            cnt   <= cnt + 20'd1;
            state <= WAIT_HI;
          end else if (state == WAIT_HI && bus.iDone) begin
            cnt   <= 20'd0;
            state <= DELAY;
          end else if (cnt >= TO_END) begin
            err_q   <= 1'b1;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end

        DELAY: begin
          if (cnt == dly_end) begin
            cnt <= 20'd0;
            if (step == STEP_LAST) begin
              ready_q <= 1'b1;
              state   <= IDLE;
            end else begin
              step  <= step + 6'd1;
              state <= LOAD;
            end
          end else begin
            cnt <= cnt + 20'd1;
          end
        end

        IDLE: begin
          if (bus.iGo) begin
            ready_q <= 1'b0;
            step    <= STEP_ROW0;
            cnt     <= 20'd0;
            state   <= LOAD;
          end
        end

        default: begin
          cnt   <= 20'd0;
          state <= PWR_WAIT;
        end
      endcase
    end
  end

  assign bus.oStart = start_q;
  assign bus.oData  = data_q;
  assign bus.oRS    = rs_q;
  assign bus.oReady = ready_q;
  assign bus.oErr   = err_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Directed bench for lcd_init_seq with a byte-controller model (iDone low 2 cycles after oStart, high 18 later).
module tb_lcd_init_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_init_seq_if bus ();

  lcd_init_seq #(
    .PWR_DLY(10),
    .CMD_DLY(4),
    .CLR_DLY(8),
    .TO_CYC (64)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  localparam logic [127:0] L1A = "HELLO WORLD     ";
  localparam logic [127:0] L1B = "ABCDEFGHIJKLMNOP";
  localparam logic [127:0] L1Z = "ZZZZZZZZZZZZZZZZ";
  localparam logic [127:0] L2  = "0123456789ABCDEF";

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_rise = 0;
  int   err_cyc = -1;
  logic prev_err = 1'b0;
  int   mcnt = -1;
  bit   stuck = 1'b0;

  logic [7:0] log_dat[$];
  logic       log_rs[$];
  int         log_cyc[$];
  int         log_gap[$];

  // Monitor + byte-controller model; sole writer of logs and iDone. Samples 1 ns after the edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.oStart) begin
      log_dat.push_back(bus.oData);
      log_rs.push_back(bus.oRS);
      log_cyc.push_back(cyc);
      log_gap.push_back(cyc - last_rise);
    end
    if (bus.oErr && !prev_err) err_cyc = cyc;
    prev_err = bus.oErr;
    if (rst) begin
      mcnt = -1;
      bus.iDone = 1'b1;
    end else if (bus.oStart && !stuck) begin
      mcnt = 0;
    end else if (mcnt >= 0) begin
      mcnt++;
      if (mcnt == 2) bus.iDone = 1'b0;
      if (mcnt == 20) begin
        bus.iDone = 1'b1;
        last_rise = cyc + 1;
        mcnt = -1;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_go();
    bus.iGo = 1'b1;
    tick();
    bus.iGo = 1'b0;
  endtask

  task automatic wait_ready(string tag, int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.oReady) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_log(string tag, int n, int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (log_dat.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  // Expected {rs, byte} straight from the step table, starting at step 'first'.
  task automatic chk_log(string tag, int b, int first, logic [127:0] l1, logic [127:0] l2);
    int n = log_dat.size() - b;
    chk({tag, "_count"}, 32'(n), 32'(38 - first));
    for (int i = 0; i < n && i < 38 - first; i++) begin
      int st;
      logic [8:0] e;
      st = first + i;
      case (st)
        0:       e = {1'b0, 8'h38};
        1:       e = {1'b0, 8'h0C};
        2:       e = {1'b0, 8'h01};
        3:       e = {1'b0, 8'h06};
        4:       e = {1'b0, 8'h80};
        21:      e = {1'b0, 8'hC0};
        default: e = (st <= 20) ? {1'b1, l1[127 - 8 * (st - 5) -: 8]}
                                : {1'b1, l2[127 - 8 * (st - 22) -: 8]};
      endcase
      chk($sformatf("%s_step%0d", tag, st), {23'd0, log_rs[b + i], log_dat[b + i]}, {23'd0, e});
    end
  endtask

  initial begin
    int base;
    int rel;
    int sc;
    int zc;

    bus.iGo    = 1'b0;
    bus.iLine1 = L1A;
    bus.iLine2 = L2;
    rst        = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", {20'd0, bus.oStart, bus.oData, bus.oRS, bus.oReady, bus.oErr}, 32'd0);

    // Full init after reset release
    rel  = cyc;
    rst  = 1'b0;
    base = 0;
    wait_ready("init_done", 3000);
    chk_log("init", base, 0, L1A, L2);
    if (log_dat.size() >= 38) begin
      chk("first_start_latency", 32'(log_cyc[base] - rel), 32'd11);
      for (int i = 1; i < 38; i++)
        chk($sformatf("gap_before_step%0d", i), 32'(log_gap[base + i]), (i == 3) ? 32'd9 : 32'd5);
    end
    chk("init_ready", 32'(bus.oReady), 32'd1);
    chk("init_err", 32'(bus.oErr), 32'd0);

    // Refresh: text edited mid-pass and a stray iGo at step 10 must both be ignored
    bus.iLine1 = L1B;
    base = log_dat.size();
    pulse_go();
    chk("ready_drop", 32'(bus.oReady), 32'd0);
    wait_log("refresh_step6", base + 3, 500);
    bus.iLine1 = L1Z;
    wait_log("refresh_step10", base + 7, 500);
    pulse_go();
    wait_ready("refresh_done", 3000);
    chk_log("refresh", base, 4, L1B, L2);
    zc = 0;
    for (int i = base; i < log_dat.size(); i++)
      if (log_dat[i] == 8'h5A) zc++;
    chk("refresh_no_second_text", 32'(zc), 32'd0);
    repeat (100) tick();
    chk("refresh_no_queued_go", 32'(log_dat.size() - base), 32'd34);
    chk("refresh_ready_hold", 32'(bus.oReady), 32'd1);

    // Handshake timeout: controller never acknowledges
    stuck = 1'b1;
    base  = log_dat.size();
    pulse_go();
    wait_log("timeout_start", base + 1, 100);
    sc = (log_cyc.size() > base) ? log_cyc[base] : 0;
    wait_ready("timeout_idle", 200);
    chk("timeout_err", 32'(bus.oErr), 32'd1);
    chk("timeout_latency", 32'(err_cyc - sc), 32'd65);
    chk("timeout_one_pulse", 32'(log_dat.size() - base), 32'd1);

    // Refresh after error runs normally, error stays sticky
    stuck = 1'b0;
    base  = log_dat.size();
    pulse_go();
    wait_ready("post_err_done", 3000);
    chk_log("post_err", base, 4, L1Z, L2);
    chk("err_sticky", 32'(bus.oErr), 32'd1);

    // Reset during step 20 of a refresh
    base = log_dat.size();
    pulse_go();
    wait_log("reach_step20", base + 17, 1000);
    rst = 1'b1;
    tick();
    chk("midrun_reset_outputs", {20'd0, bus.oStart, bus.oData, bus.oRS, bus.oReady, bus.oErr}, 32'd0);
    tick();
    rel  = cyc;
    rst  = 1'b0;
    base = log_dat.size();
    wait_ready("restart_done", 3000);
    chk_log("restart", base, 0, L1Z, L2);
    if (log_cyc.size() > base)
      chk("restart_first_latency", 32'(log_cyc[base] - rel), 32'd11);
    chk("restart_err_clear", 32'(bus.oErr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_init_seq.md
LCD_INIT_SEQ -- requirements
Module: lcd_init_seq

Interface
REQ-001 SHALL provide parameter PWR_DLY, default 750000, power-on wait in iClk cycles (15 ms at 50 MHz).
REQ-002 SHALL provide parameter CMD_DLY, default 2500, post-byte settle time in cycles (50 us).
REQ-003 SHALL provide parameter CLR_DLY, default 82000, post-clear settle time in cycles (1.64 ms).
REQ-004 SHALL provide parameter TO_CYC, default 1024, handshake timeout in cycles.
REQ-005 SHALL have one clock and a synchronous, active-high reset; ports iClk and iRst, with no other clock or reset.
REQ-006 iClk  input  1  system clock; all logic on rising edge.
REQ-007 iRst  input  1  synchronous active-high reset.
REQ-008 iGo  input  1  refresh request; sampled only in IDLE.
REQ-009 iLine1  input  128  row-0 text; bits [127:120] = column 0, [7:0] = column 15.
REQ-010 iLine2  input  128  row-1 text; same ordering.
REQ-011 iDone  input  1  byte-transfer done from downstream LCD byte controller.
REQ-012 oStart  output  1  one-cycle start pulse to byte controller.
REQ-013 oData  output  8  byte to byte controller.
REQ-014 oRS  output  1  1 = character data, 0 = instruction.
REQ-015 oReady  output  1  high in IDLE only.
REQ-016 oErr  output  1  sticky handshake-timeout flag.

Function
REQ-017 Step table, index 0..37 (6-bit): 0=0x38, 1=0x0C, 2=0x01, 3=0x06, 4=0x80, 5..20=row-0 chars, 21=0xC0, 22..37=row-1 chars; oRS=1 exactly for steps 5..20 and 22..37.
REQ-018 States: PWR_WAIT, LOAD, START, WAIT_LO, WAIT_HI, DELAY, IDLE.
REQ-019 PWR_WAIT: count PWR_DLY cycles, then LOAD with step 0.
REQ-020 LOAD: drive oData/oRS from current step; on step 4, latch iLine1/iLine2 into a 256-bit shadow; chars always read from the shadow; next START.
REQ-021 START: oStart=1 for exactly this one cycle; next WAIT_LO.
REQ-022 WAIT_LO: wait for iDone=0 (controller acknowledged), then WAIT_HI; WAIT_HI: wait for iDone=1, then DELAY.
REQ-023 oData and oRS SHALL remain constant from LOAD until DELAY exits.
REQ-024 DELAY: remain exactly CLR_DLY cycles after step 2, CMD_DLY cycles after any other step; then step+1 and LOAD, or IDLE after step 37.
REQ-025 Timeout counter resets on entering WAIT_LO; if WAIT_LO+WAIT_HI combined exceed TO_CYC cycles, set oErr=1 and go to IDLE.
REQ-026 IDLE: oReady=1; iGo=1 -> step 4, LOAD (refresh without re-init); oReady drops the cycle after iGo is taken.
REQ-027 iGo outside IDLE SHALL be ignored, not queued.
REQ-028 oErr SHALL clear only on reset; a later iGo refresh runs normally with oErr held.
REQ-029 Delay counter 20 bits; parameters beyond 2^20-1 are illegal.

Reset
REQ-030 On iRst=1 at a clock edge: state PWR_WAIT, step 0, counters 0, oStart=0, oData=0x00, oRS=0, oReady=0, oErr=0, shadow cleared.
REQ-031 iRst asserted mid-sequence SHALL abort any transfer and restart full init (PWR_WAIT) after release.
REQ-032 iRst has priority over all other inputs in the same cycle.

Verification (PWR_DLY=10, CMD_DLY=4, CLR_DLY=8, TO_CYC=64; bench byte-controller model drops iDone 2 cycles after oStart, raises it 18 cycles later)
REQ-033 Release reset, iLine1="HELLO WORLD     ", iLine2="0123456789ABCDEF" -> 38 oStart pulses; byte log 38,0C,01,06,80,48,45,...,C0,30,...,46; oRS matches REQ-017; oReady=1 at end.
REQ-034 Measure gap between iDone rise and next oStart -> 8+1 cycles after step 2, 4+1 after all others; first oStart exactly 10+1 cycles after reset release.
REQ-035 In IDLE change iLine1 to "A...", pulse iGo; change iLine1 again mid-refresh -> 34 pulses starting 0x80, first char 0x41, second value never appears.
REQ-036 Pulse iGo at step 10 of a refresh -> no extra refresh; pulse count unchanged.
REQ-037 Model never lowers iDone -> oErr=1 exactly 65 cycles after oStart, oReady=1; subsequent iGo with working model completes and oErr stays 1.
REQ-038 Assert iRst during step 20 -> outputs per REQ-030 next cycle; after release full 38-byte sequence restarts from 0x38.
